// File: rtl/w6link_host.sv
// Host-side initiator for the w6 debug link: byte-wide valid/ready on the user side,
// bit-serial MSB-first transfers on the link, with CTS handshaking and timeout abort.
module w6link_host #(
  parameter int HALF_PERIOD = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       rx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       timeout_err,
  output logic       link_clk,
  output logic       link_dir,
  output logic       link_rts,
  input  logic       link_cts,
  output logic       link_mosi,
  input  logic       link_miso
);

  localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WAIT_CTS, SHIFT_LO, SHIFT_HI, RELEASE} state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              is_wr_q, is_wr_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic              link_clk_q, link_clk_d;
  logic              link_dir_q, link_dir_d;
  logic              link_rts_q, link_rts_d;
  logic              link_mosi_q, link_mosi_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              timeout_err_q, timeout_err_d;
  logic              cts_meta_q, cts_sync_q;
  logic              miso_meta_q, miso_sync_q;
  logic              abort;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    is_wr_d       = is_wr_q;
    tmo_d         = tmo_q;
    link_clk_d    = link_clk_q;
    link_dir_d    = link_dir_q;
    link_rts_d    = link_rts_q;
    link_mosi_d   = link_mosi_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    timeout_err_d = 1'b0;
    abort         = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Writes take priority; a pending rx_req is picked up on the next visit to IDLE.
        if (tx_valid) begin
          state_d    = WAIT_CTS;
          is_wr_d    = 1'b1;
          shift_d    = tx_data;
          link_dir_d = 1'b1;
          link_rts_d = 1'b1;
          tmo_d      = '0;
        end else if (rx_req) begin
          state_d    = WAIT_CTS;
          is_wr_d    = 1'b0;
          link_dir_d = 1'b0;
          link_rts_d = 1'b1;
          tmo_d      = '0;
        end
      end
      WAIT_CTS: begin
        if (cts_sync_q) begin
          state_d     = SHIFT_LO;
          bit_idx_d   = 3'd7;
          phase_d     = '0;
          link_mosi_d = is_wr_q & shift_q[7];
        end else if (tmo_q == TO_LAST) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SHIFT_LO: begin
        if (phase_q == PH_LAST) begin
          phase_d    = '0;
          state_d    = SHIFT_HI;
          link_clk_d = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (phase_q == PH_LAST) begin
          // The shift register serves both directions: MSB goes out, miso comes in at the LSB.
          phase_d    = '0;
          link_clk_d = 1'b0;
          shift_d    = {shift_q[6:0], miso_sync_q};
          if (bit_idx_q == 3'd0) begin
            state_d     = RELEASE;
            link_rts_d  = 1'b0;
            link_mosi_d = 1'b0;
            tmo_d       = '0;
          end else begin
            state_d     = SHIFT_LO;
            bit_idx_d   = bit_idx_q - 1'b1;
            link_mosi_d = is_wr_q & shift_q[6];
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!cts_sync_q) begin
          state_d    = IDLE;
          link_dir_d = 1'b0;
          if (!is_wr_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end
        end else if (tmo_q == TO_LAST) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d       = IDLE;
      link_rts_d    = 1'b0;
      link_dir_d    = 1'b0;
      link_clk_d    = 1'b0;
      link_mosi_d   = 1'b0;
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      is_wr_q       <= 1'b0;
      tmo_q         <= '0;
      link_clk_q    <= 1'b0;
      link_dir_q    <= 1'b0;
      link_rts_q    <= 1'b0;
      link_mosi_q   <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      cts_meta_q    <= 1'b0;
      cts_sync_q    <= 1'b0;
      miso_meta_q   <= 1'b0;
      miso_sync_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      is_wr_q       <= is_wr_d;
      tmo_q         <= tmo_d;
      link_clk_q    <= link_clk_d;
      link_dir_q    <= link_dir_d;
      link_rts_q    <= link_rts_d;
      link_mosi_q   <= link_mosi_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      timeout_err_q <= timeout_err_d;
      cts_meta_q    <= link_cts;
      cts_sync_q    <= cts_meta_q;
      miso_meta_q   <= link_miso;
      miso_sync_q   <= miso_meta_q;
    end
  end

  assign tx_ready    = (state_q == IDLE) & rst;
  assign busy        = (state_q != IDLE);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign timeout_err = timeout_err_q;
  assign link_clk    = link_clk_q;
  assign link_dir    = link_dir_q;
  assign link_rts    = link_rts_q;
  assign link_mosi   = link_mosi_q;

endmodule

// File: tb/tb_w6link_host.sv
// Directed bench for w6link_host: a behavioural w6 target answers CTS and drives miso,
// a monitor records link_clk rises and mosi bits for the checks.
module tb_w6link_host;

  localparam int HP = 2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       rx_req = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       timeout_err;
  logic       link_clk;
  logic       link_dir;
  logic       link_rts;
  logic       link_cts = 1'b0;
  logic       link_mosi;
  logic       link_miso = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  w6link_host #(.HALF_PERIOD(HP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_req(rx_req), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .timeout_err(timeout_err),
    .link_clk(link_clk), .link_dir(link_dir), .link_rts(link_rts),
    .link_cts(link_cts), .link_mosi(link_mosi), .link_miso(link_miso)
  );

  // Target model: raises CTS t_delay cycles after RTS, drops it once RTS falls,
  // presents the MSB with CTS and the next bit after each link_clk fall.
  int         t_delay  = 10;
  bit         t_cts_en = 1'b1;
  logic [7:0] t_byte   = 8'h00;
  int         t_wait   = 0;
  int         t_bit    = -1;
  logic       t_prev   = 1'b0;

  always @(posedge clk) begin
    t_prev <= link_clk;
    if (!link_rts) begin
      link_cts <= 1'b0;
      t_wait   <= 0;
    end else if (!link_cts && t_cts_en) begin
      if (t_wait >= t_delay) begin
        link_cts  <= 1'b1;
        link_miso <= t_byte[7];
        t_bit     <= 6;
      end else begin
        t_wait <= t_wait + 1;
      end
    end
    if (!link_clk && t_prev && link_cts && t_bit >= 0) begin
      link_miso <= t_byte[t_bit];
      t_bit     <= t_bit - 1;
    end
  end

  int   cyc = 0;
  int   rise_t[$];
  logic rise_b[$];
  int   hi_cnt = 0;
  int   dirhi_cnt = 0;
  int   rxv_cnt = 0;
  int   terr_cnt = 0;
  logic m_prev = 1'b0;

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    m_prev <= link_clk;
    if (link_clk && !m_prev) begin
      rise_t.push_back(cyc);
      rise_b.push_back(link_mosi);
    end
    if (link_clk) hi_cnt <= hi_cnt + 1;
    if (busy && link_dir) dirhi_cnt <= dirhi_cnt + 1;
    if (rx_valid) rxv_cnt <= rxv_cnt + 1;
    if (timeout_err) terr_cnt <= terr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [7:0] bits_at(input int s);
    logic [7:0] v = 8'h00;
    if (s + 8 > rise_b.size()) return 8'hxx;
    for (int i = 0; i < 8; i++) v = {v[6:0], rise_b[s+i]};
    return v;
  endfunction

  task automatic send(input logic [7:0] b);
    bit ok = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (tx_ready) ok = 1'b1;
      step();
    end
    tx_valid = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic req_read();
    bit ok = 1'b0;
    rx_req = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (tx_ready && !tx_valid) ok = 1'b1;
      step();
    end
    rx_req = 1'b0;
    chk("read_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (!busy) ok = 1'b1;
      else step();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_rxv(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (rx_valid) ok = 1'b1;
      else step();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int base_r, base_hi, base_v, base_dh, base_t, first, bad;
    bit ok;

    // Reset state
    step_n(3);
    chk("rst_tx_ready", 32'(tx_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_link_clk", 32'(link_clk), 0);
    chk("rst_link_dir", 32'(link_dir), 0);
    chk("rst_link_rts", 32'(link_rts), 0);
    chk("rst_link_mosi", 32'(link_mosi), 0);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    rst = 1'b1;
    step();
    chk("post_rst_tx_ready", 32'(tx_ready), 1);

    // Write 0xA5, CTS after 10 cycles
    t_delay = 10;
    base_r  = rise_t.size();
    base_v  = rxv_cnt;
    send(8'hA5);
    chk("wr_busy", 32'(busy), 1);
    chk("wr_rts", 32'(link_rts), 1);
    chk("wr_dir", 32'(link_dir), 1);
    chk("wr_tx_ready", 32'(tx_ready), 0);
    wait_idle("wr_done");
    chk("wr_rises", 32'(rise_t.size() - base_r), 8);
    chk("wr_bits", 32'(bits_at(base_r)), 32'hA5);
    chk("wr_rts_off", 32'(link_rts), 0);
    chk("wr_dir_off", 32'(link_dir), 0);
    chk("wr_no_rxv", 32'(rxv_cnt - base_v), 0);

    // Read 0x3C
    t_delay = 3;
    t_byte  = 8'h3C;
    base_v  = rxv_cnt;
    base_dh = dirhi_cnt;
    req_read();
    chk("rd_busy", 32'(busy), 1);
    chk("rd_rts", 32'(link_rts), 1);
    chk("rd_dir", 32'(link_dir), 0);
    wait_rxv("rd_valid");
    chk("rd_data", 32'(rx_data), 32'h3C);
    chk("rd_idle", 32'(busy), 0);
    step();
    chk("rd_pulse_end", 32'(rx_valid), 0);
    chk("rd_pulse_count", 32'(rxv_cnt - base_v), 1);
    chk("rd_dir_low", 32'(dirhi_cnt - base_dh), 0);

    // Simultaneous tx_valid and rx_req: write first, then read
    t_byte   = 8'hC3;
    base_r   = rise_t.size();
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    rx_req   = 1'b1;
    step();
    tx_valid = 1'b0;
    chk("both_first_dir", 32'(link_dir), 1);
    chk("both_tx_ready", 32'(tx_ready), 0);
    ok  = 1'b0;
    bad = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (link_rts && tx_ready) bad++;
      if (link_rts && !link_dir) ok = 1'b1;
      else step();
    end
    rx_req = 1'b0;
    chk("both_read_started", 32'(ok), 1);
    chk("both_wr_rises", 32'(rise_t.size() - base_r), 8);
    wait_rxv("both_rd_valid");
    chk("both_rd_data", 32'(rx_data), 32'hC3);
    chk("both_wr_bits", 32'(bits_at(base_r)), 32'h5A);
    chk("both_tx_ready_low", 32'(bad), 0);

    // CTS never asserted: timeout
    t_cts_en = 1'b0;
    base_t   = terr_cnt;
    send(8'h77);
    chk("to_rts_up", 32'(link_rts), 1);
    first = 0;
    for (int i = 1; i <= 24 && first == 0; i++) begin
      step();
      if (timeout_err) first = i;
    end
    chk("to_cycle", 32'(first), 32'(TO));
    chk("to_rts", 32'(link_rts), 0);
    chk("to_dir", 32'(link_dir), 0);
    chk("to_clk", 32'(link_clk), 0);
    chk("to_tx_ready", 32'(tx_ready), 1);
    chk("to_rx_data", 32'(rx_data), 32'hC3);
    step();
    chk("to_pulse_end", 32'(timeout_err), 0);
    chk("to_pulse_count", 32'(terr_cnt - base_t), 1);
    t_cts_en = 1'b1;
    step_n(4);

    // Reset asserted during bit 4 of a read
    t_delay = 2;
    t_byte  = 8'h96;
    base_v  = rxv_cnt;
    base_r  = rise_t.size();
    req_read();
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (rise_t.size() - base_r >= 4) ok = 1'b1;
      else step();
    end
    chk("mid_bit4_reached", 32'(ok), 1);
    rst = 1'b0;
    step();
    chk("mid_link_clk", 32'(link_clk), 0);
    chk("mid_link_dir", 32'(link_dir), 0);
    chk("mid_link_rts", 32'(link_rts), 0);
    chk("mid_link_mosi", 32'(link_mosi), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_tx_ready", 32'(tx_ready), 0);
    chk("mid_rx_data", 32'(rx_data), 32'h00);
    rst = 1'b1;
    step_n(8);
    chk("mid_no_rxv", 32'(rxv_cnt - base_v), 0);
    chk("mid_idle", 32'(busy), 0);

    // Back-to-back writes 0xFF, 0x00
    t_delay = 1;
    base_r  = rise_t.size();
    base_hi = hi_cnt;
    send(8'hFF);
    send(8'h00);
    wait_idle("b2b_done");
    step_n(4);
    chk("b2b_rises", 32'(rise_t.size() - base_r), 16);
    chk("b2b_hi_cycles", 32'(hi_cnt - base_hi), 32'(16 * HP));
    chk("b2b_bits0", 32'(bits_at(base_r)), 32'hFF);
    chk("b2b_bits1", 32'(bits_at(base_r + 8)), 32'h00);
    bad = 0;
    if (rise_t.size() >= base_r + 16) begin
      for (int b = 0; b < 2; b++)
        for (int i = 1; i < 8; i++)
          if (rise_t[base_r+8*b+i] - rise_t[base_r+8*b+i-1] != 2 * HP) bad++;
    end else begin
      bad = 99;
    end
    chk("b2b_period", 32'(bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
